// File: rtl/pipe_pkg.sv
// Shared types and constants for the RV32I pipeline control logic.
// Includes the forwarding-select helper used for both Execute operands.
package pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  // Memory stage wins over Writeback; x0 is never a forwarding source.
  function automatic fwd_sel_t fwd_select(
    input logic       rw_m,
    input logic [4:0] rd_m,
    input logic       rw_w,
    input logic [4:0] rd_w,
    input logic [4:0] rs
  );
    fwd_sel_t sel;
    if (rw_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = FWD_M;
    end else if (rw_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = FWD_W;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Count register: reset, then clear, then saturating increment.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r <= {W{1'b0}};
    end else if (clr) begin
      count_r <= {W{1'b0}};
    end else if (inc && (count_r != {W{1'b1}})) begin
      count_r <= count_r + W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: forwarding, load-use/branch stall and flush,
// data-memory wait FSM with timeout flag, and stall/flush perf counters.
module hazard_unit
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemAckM,
  input  logic             CntClear,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  mem_state_t        state_r, state_nxt_s;
  logic [WAIT_W-1:0] wait_cnt_r, wait_nxt_s;
  logic              mem_err_r, err_set_s;
  logic              lw_stall_s, mem_stall_s, flush_inc_s;

  assign ForwardAE = fwd_select(RegWriteM, RdM, RegWriteW, RdW, Rs1E);
  assign ForwardBE = fwd_select(RegWriteM, RdM, RegWriteW, RdW, Rs2E);

  assign lw_stall_s = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != 5'd0) &&
                      ((Rs1D == RdE) || (Rs2D == RdE));
  // An ack in the wait state releases the pipe in the same cycle.
  assign mem_stall_s = !MemAckM && ((state_r == MEM_WAIT) || MemReqM);

  // Stall/flush generation; a memory wait holds any pending redirect.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (mem_stall_s) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = lw_stall_s && !PCSrcE;
      StallD = lw_stall_s && !PCSrcE;
      FlushD = PCSrcE;
      FlushE = PCSrcE || lw_stall_s;
    end
  end

  // Memory wait FSM next-state and timeout detection.
  always_comb begin
    state_nxt_s = state_r;
    wait_nxt_s  = wait_cnt_r;
    err_set_s   = 1'b0;
    case (state_r)
      IDLE: begin
        wait_nxt_s = {WAIT_W{1'b0}};
        if (MemReqM && !MemAckM) begin
          state_nxt_s = MEM_WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MEM_WAIT: begin
        if (MemAckM) begin
          state_nxt_s = IDLE;
          wait_nxt_s  = {WAIT_W{1'b0}};
        end else if (wait_cnt_r == WAIT_LAST) begin
          state_nxt_s = IDLE;
          wait_nxt_s  = {WAIT_W{1'b0}};
          err_set_s   = 1'b1;
        end else begin
          state_nxt_s = MEM_WAIT;
          wait_nxt_s  = wait_cnt_r + WAIT_W'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
        wait_nxt_s  = {WAIT_W{1'b0}};
      end
    endcase
  end

  // FSM state, wait counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= IDLE;
      wait_cnt_r <= {WAIT_W{1'b0}};
      mem_err_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_nxt_s;
      mem_err_r  <= mem_err_r || err_set_s;
    end
  end

  assign MemErr      = mem_err_r;
  assign flush_inc_s = PCSrcE && !mem_stall_s;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (StallF),
    .clr   (CntClear),
    .count (StallCnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc_s),
    .clr   (CntClear),
    .count (FlushCnt)
  );

endmodule
